param_alu_acc: RTL
==================

PARAM_ALU_ACC -- requirements
Module: param_alu_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 8, result/accumulator width in bits; ACC_WIDTH >= 2*WIDTH SHALL hold, otherwise elaboration fails.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_valid  input  1  request; accepted on a clk edge when in_valid=1 and busy=0.
REQ-007 Port: op  input  2  0=ADD, 1=SUB, 2=ACC, 3=MUL; sampled at accept.
REQ-008 Port: a, b  input  WIDTH  operands, sampled at accept.
REQ-009 Port: acc_clr  input  1  synchronous clear of accumulator and overflow.
REQ-010 Port: result  output  ACC_WIDTH  registered result; holds until the next out_valid.
REQ-011 Port: carry  output  1  carry/borrow/wrap of the last completed op.
REQ-012 Port: overflow  output  1  sticky accumulator-wrap flag.
REQ-013 Port: out_valid  output  1  one-cycle pulse per completed op.
REQ-014 Port: busy  output  1  multiplier running; requests are ignored, not queued.

Function
REQ-015 ADD, SUB and ACC SHALL complete in one cycle: an accept at edge k SHALL raise out_valid for the cycle after edge k.
REQ-016 ADD SHALL give result = zero-extended {carry, a+b}, with carry = bit WIDTH of the sum.
REQ-017 SUB SHALL give result = zero-extended (a-b) mod 2^WIDTH, with carry = 1 iff a < b (borrow).
REQ-018 ACC SHALL update acc <= (acc + a + b) mod 2^ACC_WIDTH and set result = new acc; carry = 1 iff this update wrapped; a wrap SHALL set overflow, which stays 1 until acc_clr or reset.
REQ-019 MUL SHALL be a shift-add multiplier with FSM states IDLE -> RUN -> IDLE.
REQ-020 On a MUL accept the FSM SHALL go IDLE -> RUN, with busy=1 for exactly WIDTH cycles.
REQ-021 On the last RUN iteration the FSM SHALL return to IDLE; busy=0 and out_valid=1 in the same following cycle; result = a*b zero-extended; carry = 0.
REQ-022 A new request SHALL be acceptable in the cycle where MUL out_valid=1.
REQ-023 in_valid while busy=1 SHALL have no effect on any output or state.
REQ-024 acc_clr SHALL clear acc and overflow at the next edge.
REQ-025 When acc_clr and an ACC accept occur on the same edge, the clear SHALL apply first: acc <= a+b, overflow <= wrap of that sum.
REQ-026 acc_clr SHALL NOT alter result, carry, out_valid or an in-flight MUL.
REQ-027 ADD, SUB and MUL SHALL NOT modify acc or overflow.
REQ-028 Back-to-back accepts of one-cycle ops SHALL produce out_valid on consecutive cycles with no bubble.

Reset
REQ-029 rst_n=0 SHALL asynchronously force result=0, carry=0, overflow=0, out_valid=0, busy=0, acc=0 and FSM=IDLE, including mid-MUL; the aborted MUL SHALL produce no out_valid.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package param_alu_pkg SHALL hold the op encoding (OP_ADD, OP_SUB, OP_ACC, OP_MUL) and the FSM state enum (IDLE, RUN).
REQ-032 The shift-add multiplier SHALL be a sub-module seq_mul (ports: start, a, b, busy, done, product); the top SHALL hold the accumulator, flags and output registers.

Verification (WIDTH=4, ACC_WIDTH=8)
REQ-033 ADD a=9, b=8 -> next cycle out_valid=1, result=0x11, carry=1; SUB a=3, b=5 -> result=0x0E, carry=1.
REQ-034 acc_clr, then 9 consecutive ACC a=15, b=15 -> results 30, 60, ..., 240, then 14 with carry=1 and overflow=1; then ADD 1+1 -> overflow stays 1.
REQ-035 MUL a=15, b=13 -> busy=1 for 4 cycles, then result=0xC3 (195) with out_valid; ADD pulses during busy produce no out_valid.
REQ-036 acc_clr with ACC a=2, b=3 on the same edge while acc=200 and overflow=1 -> acc=5, overflow=0.
REQ-037 rst_n low during cycle 2 of MUL -> busy=0 and all outputs 0 immediately; no out_valid after release; a subsequent ADD 1+2 -> result=3.

Source files
------------

// File: rtl/param_alu_pkg.sv
// Shared encodings for the parameterised ALU/accumulator: operation codes
// and the multiplier sequencing states.
package param_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_MUL = 2'd3
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles in RUN.
// done/product flag the final iteration so the caller can register the result.
module seq_mul
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e         state_r, state_n;
    logic [CW-1:0]      cnt_r, cnt_n;
    logic [2*WIDTH-1:0] mcand_r, mcand_n;
    logic [WIDTH-1:0]   mplier_r, mplier_n;
    logic [2*WIDTH-1:0] prod_r, prod_n;
    logic [2*WIDTH-1:0] prod_step;
    logic               last_iter;

    assign prod_step = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign last_iter = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
    assign busy      = (state_r == RUN);
    assign done      = last_iter;
    assign product   = prod_step;

    // Next-state and datapath update for the shift-add sequence.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        mcand_n  = mcand_r;
        mplier_n = mplier_r;
        prod_n   = prod_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n  = RUN;
                    cnt_n    = {CW{1'b0}};
                    mcand_n  = {{WIDTH{1'b0}}, a};
                    mplier_n = b;
                    prod_n   = {(2*WIDTH){1'b0}};
                end else begin
                    state_n  = IDLE;
                end
            end
            RUN: begin
                prod_n   = prod_step;
                mcand_n  = mcand_r << 1;
                mplier_n = mplier_r >> 1;
                cnt_n    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (last_iter) begin
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            mcand_r  <= mcand_n;
            mplier_r <= mplier_n;
            prod_r   <= prod_n;
        end
    end

endmodule

// File: rtl/param_alu_acc.sv
// Small ALU with add/sub, a wrapping accumulator with sticky overflow, and a
// multi-cycle multiplier; all results and flags are registered.
module param_alu_acc
    import param_alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_clr,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 carry,
    output logic                 overflow,
    output logic                 out_valid,
    output logic                 busy
);

    if (ACC_WIDTH < 2 * WIDTH) begin : g_width_check
        $error("param_alu_acc: ACC_WIDTH must be at least 2*WIDTH");
    end

    logic                 accept;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_r, acc_n;
    logic [ACC_WIDTH-1:0] result_n;
    logic                 carry_n, ovf_n, valid_n;

    // Requests arriving while the multiplier runs are dropped, not queued.
    assign accept    = in_valid & ~mul_busy;
    assign mul_start = accept & (op_e'(op) == OP_MUL);
    assign busy      = mul_busy;

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Clear takes effect before a same-edge ACC, so the sum starts from zero.
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        sub_diff = {1'b0, a} - {1'b0, b};
        if (acc_clr) begin
            acc_base = {ACC_WIDTH{1'b0}};
            ovf_n    = 1'b0;
        end else begin
            acc_base = acc_r;
            ovf_n    = overflow;
        end
        acc_sum  = {1'b0, acc_base} + (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
        acc_n    = acc_base;
        result_n = result;
        carry_n  = carry;
        valid_n  = 1'b0;
        if (mul_done) begin
            result_n = ACC_WIDTH'(mul_product);
            carry_n  = 1'b0;
            valid_n  = 1'b1;
        end else if (accept) begin
            case (op_e'(op))
                OP_ADD: begin
                    result_n = ACC_WIDTH'(add_sum);
                    carry_n  = add_sum[WIDTH];
                    valid_n  = 1'b1;
                end
                OP_SUB: begin
                    result_n = ACC_WIDTH'(sub_diff[WIDTH-1:0]);
                    carry_n  = sub_diff[WIDTH];
                    valid_n  = 1'b1;
                end
                OP_ACC: begin
                    acc_n    = acc_sum[ACC_WIDTH-1:0];
                    result_n = acc_sum[ACC_WIDTH-1:0];
                    carry_n  = acc_sum[ACC_WIDTH];
                    ovf_n    = ovf_n | acc_sum[ACC_WIDTH];
                    valid_n  = 1'b1;
                end
                OP_MUL: begin
                    valid_n = 1'b0;
                end
                default: begin
                    valid_n = 1'b0;
                end
            endcase
        end else begin
            valid_n = 1'b0;
        end
    end

    // Accumulator, flags and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {ACC_WIDTH{1'b0}};
            result    <= {ACC_WIDTH{1'b0}};
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc_r     <= acc_n;
            result    <= result_n;
            carry     <= carry_n;
            overflow  <= ovf_n;
            out_valid <= valid_n;
        end
    end

endmodule
